// File: rtl/steel_mem_pkg.sv
// Shared types and constants for the steel memory subsystem: controller FSM states
// and the range of supported read latencies.
package steel_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } mem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/steel_mem_rdpipe.sv
// Output register chain for one read port. The stage inside the RAM supplies
// the first cycle of latency; each cycle beyond that adds one resettable register here.
module steel_mem_rdpipe
    import steel_mem_pkg::*;
#(
    parameter int W      = 32,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] data,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [RD_LAT];

    assign chain[0] = data;

    generate
        for (genvar gi = 0; gi < RD_LAT - 1; gi++) begin : g_stage
            logic [W-1:0] stage_reg;

            // There is no stall input, so every stage moves forward on every cycle.
            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= chain[gi];
                end
            end

            assign chain[gi+1] = stage_reg;
        end
    endgenerate

    assign q = chain[RD_LAT-1];

endmodule

// File: rtl/steel_mem_subsys.sv
// Dual-port word memory for a core: an instruction read port and a data
// read/write port with byte lanes, and a zero-fill sweep that runs after reset.
module steel_mem_subsys
    import steel_mem_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         I_ADDR,
    output logic [DATA_W-1:0]   INSTR,
    input  logic [31:0]         D_ADDR,
    input  logic [DATA_W-1:0]   DATA_OUT,
    input  logic                WR_REQ,
    input  logic [DATA_W/8-1:0] WR_MASK,
    output logic [DATA_W-1:0]   DATA_IN,
    output logic                READY
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    generate
        if (!rd_lat_legal(RD_LAT) || (DATA_W % 8 != 0)) begin : g_param_check
            $error("steel_mem_subsys: RD_LAT must be 1 or 2 and DATA_W a multiple of 8");
        end
    endgenerate

    mem_state_e          state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic                ready_reg;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   i_q_reg, d_q_reg;

    logic [ADDR_W-1:0]   i_idx, d_idx;
    logic [ADDR_W-1:0]   a_idx;
    logic [DATA_W-1:0]   a_wdata;
    logic [NBYTES-1:0]   a_lanes;
    logic                unused_addr_bits;

    // Byte offset and the bits above the word index alias silently.
    assign i_idx = I_ADDR[ADDR_W+1:2];
    assign d_idx = D_ADDR[ADDR_W+1:2];
    assign unused_addr_bits = ^{I_ADDR[31:ADDR_W+2], I_ADDR[1:0],
                                D_ADDR[31:ADDR_W+2], D_ADDR[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next   = '0;
                state_next = (INIT_ZERO != 0) ? INIT : RUN;
            end
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == {ADDR_W{1'b1}}) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= (state_next == RUN);
        end
    end

    // The sweep borrows the data port, so the array keeps one write port.
    always_comb begin
        a_idx   = d_idx;
        a_wdata = DATA_OUT;
        a_lanes = '0;
        if (!RESET) begin
            if (state_reg == INIT) begin
                a_idx   = cnt_reg;
                a_wdata = '0;
                a_lanes = '1;
            end else if ((state_reg == RUN) && WR_REQ) begin
                a_lanes = WR_MASK;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (a_lanes[b]) begin
                mem[a_idx][b*8 +: 8] <= a_wdata[b*8 +: 8];
            end
        end
    end

    // Data port is write-first (merged word); instruction port reads the old word.
    always_ff @(posedge CLK) begin
        if (RESET || (state_reg != RUN)) begin
            i_q_reg <= '0;
            d_q_reg <= '0;
        end else begin
            i_q_reg <= mem[i_idx];
            for (int b = 0; b < NBYTES; b++) begin
                d_q_reg[b*8 +: 8] <= a_lanes[b] ? a_wdata[b*8 +: 8] : mem[d_idx][b*8 +: 8];
            end
        end
    end

    steel_mem_rdpipe #(
        .W      (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_instr_pipe (
        .clk  (CLK),
        .srst (RESET),
        .data (i_q_reg),
        .q    (INSTR)
    );

    steel_mem_rdpipe #(
        .W      (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_data_pipe (
        .clk  (CLK),
        .srst (RESET),
        .data (d_q_reg),
        .q    (DATA_IN)
    );

    assign READY = ready_reg;

endmodule

// File: tb/tb_steel_mem_subsys.sv
// Bench for steel_mem_subsys: a swept, latency-1 instance and an unswept, latency-2
// instance share one stimulus stream and are compared against a word-array model.
module tb_steel_mem_subsys;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] I_ADDR, D_ADDR, DATA_OUT;
    logic        WR_REQ;
    logic [3:0]  WR_MASK;

    logic [31:0] instr1, din1, instr2, din2;
    logic        ready1, ready2;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] hist_i, hist_d;
    bit          hist_ok   = 0;
    bit          dut2_sync = 0;

    logic [31:0] r_ia, r_da, r_dat;
    logic        r_wr;
    logic [3:0]  r_m;
    int          low_cycles;

    always #5 CLK = ~CLK;

    steel_mem_subsys #(.ADDR_W(4), .DATA_W(32), .RD_LAT(1), .INIT_ZERO(1)) u_dut (
        .CLK(CLK), .RESET(RESET), .I_ADDR(I_ADDR), .INSTR(instr1), .D_ADDR(D_ADDR),
        .DATA_OUT(DATA_OUT), .WR_REQ(WR_REQ), .WR_MASK(WR_MASK), .DATA_IN(din1), .READY(ready1)
    );

    steel_mem_subsys #(.ADDR_W(4), .DATA_W(32), .RD_LAT(2), .INIT_ZERO(0)) u_dut_lat2 (
        .CLK(CLK), .RESET(RESET), .I_ADDR(I_ADDR), .INSTR(instr2), .D_ADDR(D_ADDR),
        .DATA_OUT(DATA_OUT), .WR_REQ(WR_REQ), .WR_MASK(WR_MASK), .DATA_IN(din2), .READY(ready2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        hist_ok = 0;
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dat,
                         input logic wr, input logic [3:0] m);
        I_ADDR   = ia;
        D_ADDR   = da;
        DATA_OUT = dat;
        WR_REQ   = wr;
        WR_MASK  = m;
    endtask

    // One cycle with both instances running; model: instruction port sees the
    // word before this cycle's write, data port sees it after.
    task automatic txn(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dat,
                       input logic wr, input logic [3:0] m);
        logic [31:0] ei, ed;
        int          wd;
        ei = ref_mem[widx(ia)];
        wd = widx(da);
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) ref_mem[wd][8*b +: 8] = dat[8*b +: 8];
            end
        end
        ed = ref_mem[wd];
        drive(ia, da, dat, wr, m);
        @(posedge CLK);
        #1;
        check_val("instr_lat1", instr1, ei);
        check_val("data_lat1", din1, ed);
        if (dut2_sync && hist_ok) begin
            check_val("instr_lat2", instr2, hist_i);
            check_val("data_lat2", din2, hist_d);
        end
        hist_i  = ei;
        hist_d  = ed;
        hist_ok = 1;
        $display("txn ia=%h da=%h wr=%0d m=%h dat=%h instr=%h din=%h", ia, da, wr, m, dat, instr1, din1);
    endtask

    // Counts cycles with READY low after the first post-release edge.
    task automatic count_sweep(input string tag);
        tick();
        low_cycles = 0;
        while (ready1 == 1'b0 && low_cycles < 40) begin
            check_val({tag, "_instr_zero"}, instr1, 32'h0);
            low_cycles++;
            tick();
        end
        check_val(tag, low_cycles, 32'd16);
    endtask

    initial begin
        RESET = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 4'h0);
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h0;

        repeat (3) tick();
        check_val("rst_ready1", {31'b0, ready1}, 32'd0);
        check_val("rst_ready2", {31'b0, ready2}, 32'd0);
        check_val("rst_instr1", instr1, 32'h0);
        check_val("rst_din1", din1, 32'h0);
        check_val("rst_instr2", instr2, 32'h0);
        check_val("rst_din2", din2, 32'h0);

        // Release: unswept instance is ready at once, swept one after 16 cycles.
        RESET = 1'b0;
        tick();
        check_val("noinit_ready", {31'b0, ready2}, 32'd1);
        low_cycles = 1;
        while (ready1 == 1'b0 && low_cycles < 40) begin
            tick();
            if (ready1 == 1'b0) low_cycles++;
        end
        check_val("sweep_len", low_cycles, 32'd16);

        for (int w = 0; w < DEPTH; w++) begin
            drive(w * 4, w * 4, 32'h0, 1'b0, 4'hF);
            tick();
            check_val("swept_instr", instr1, 32'h0);
            check_val("swept_data", din1, 32'h0);
        end

        // Fill every word so both instances hold identical contents.
        for (int w = 0; w < DEPTH; w++) begin
            r_dat = $urandom;
            txn(w * 4, w * 4, r_dat, 1'b1, 4'hF);
        end
        tick();
        dut2_sync = 1;

        txn(32'h0, 32'h8, 32'hDEADBEEF, 1'b1, 4'hF);
        txn(32'h0, 32'h8, 32'h11223344, 1'b1, 4'h3);
        check_val("mask_merge", din1, 32'hDEAD3344);
        txn(32'h0, 32'h8, 32'h0, 1'b0, 4'h0);
        check_val("mask_merge_lat2", din2, 32'hDEAD3344);

        txn(32'h4, 32'h4, 32'hAAAAAAAA, 1'b1, 4'hF);
        txn(32'h4, 32'h4, 32'h55555555, 1'b1, 4'hF);
        check_val("collide_data", din1, 32'h55555555);
        check_val("collide_instr", instr1, 32'hAAAAAAAA);

        txn(32'h0, 32'h40, 32'h12345678, 1'b1, 4'hF);
        txn(32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 4'hF);
        check_val("alias_i0", instr1, 32'h12345678);
        check_val("nowr_data", din1, 32'h12345678);
        txn(32'h3, 32'h0, 32'h0, 1'b0, 4'hF);
        check_val("alias_i3", instr1, 32'h12345678);

        for (int n = 0; n < 150; n++) begin
            r_ia  = $urandom;
            r_da  = ($urandom_range(0, 3) == 0) ? r_ia : $urandom;
            r_dat = $urandom;
            r_wr  = 1'($urandom_range(0, 1));
            r_m   = 4'($urandom_range(0, 15));
            txn(r_ia, r_da, r_dat, r_wr, r_m);
        end

        // Reset, abort the sweep after 7 words, and expect a full fresh sweep.
        drive(32'h0, 32'h0, 32'h0, 1'b0, 4'h0);
        RESET = 1'b1;
        repeat (2) tick();
        check_val("rst2_din2", din2, 32'h0);
        check_val("rst2_ready1", {31'b0, ready1}, 32'd0);
        RESET = 1'b0;
        repeat (8) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        count_sweep("resweep_len");
        check_val("rst2_ready2", {31'b0, ready2}, 32'd1);

        for (int w = 0; w < DEPTH; w++) begin
            drive(w * 4, w * 4, 32'h0, 1'b0, 4'hF);
            repeat (2) tick();
            check_val("resweep_zero", din1, 32'h0);
            check_val("kept_contents", din2, ref_mem[w]);
            check_val("kept_instr", instr2, ref_mem[w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/steel_mem_subsys.md
STEEL_MEM_SUBSYS -- requirements
Module: steel_mem_subsys

Interface
REQ-001 Parameter: ADDR_W, 11, word-address width; depth = 2^ADDR_W words.
REQ-002 Parameter: DATA_W, 32, word width; SHALL be a multiple of 8; NBYTES = DATA_W/8.
REQ-003 Parameter: RD_LAT, 1, read latency in cycles on both ports; legal values 1 or 2.
REQ-004 Parameter: INIT_ZERO, 1, 1 = zero-fill sweep after reset; 0 = no sweep.
REQ-005 Port: CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: RESET  in  1  synchronous, active-high reset.
REQ-007 Port: I_ADDR  in  32  instruction byte address.
REQ-008 Port: INSTR  out  DATA_W  instruction read data.
REQ-009 Port: D_ADDR  in  32  data byte address.
REQ-010 Port: DATA_OUT  in  DATA_W  write data from the core.
REQ-011 Port: WR_REQ  in  1  data write request.
REQ-012 Port: WR_MASK  in  NBYTES  byte-lane write enables.
REQ-013 Port: DATA_IN  out  DATA_W  data read data to the core.
REQ-014 Port: READY  out  1  high when the memory accepts accesses.

Function
REQ-015 Word index = ADDR[ADDR_W+1:2] on both ports; bits [1:0] and bits above ADDR_W+1 SHALL be ignored (aliasing, no error).
REQ-016 FSM states: IDLE (in reset), INIT (sweep), RUN. RESET forces IDLE. On the first non-reset cycle, go to INIT if INIT_ZERO=1, else to RUN.
REQ-017 INIT writes all-zero to word cnt each cycle, with cnt running 0..2^ADDR_W-1. After writing the last word, go to RUN. Duration is exactly 2^ADDR_W cycles.
REQ-018 READY = 1 only in RUN, registered. It rises on the cycle after the last sweep write.
REQ-019 In INIT and IDLE, WR_REQ SHALL be ignored. INSTR and DATA_IN SHALL read 0.
REQ-020 In RUN, when WR_REQ=1, each byte lane b with WR_MASK[b]=1 SHALL be written from DATA_OUT lane b. Lanes with a 0 mask bit keep their value. WR_REQ=0 SHALL write nothing, whatever WR_MASK is.
REQ-021 Reads on both ports SHALL be unconditional every cycle. Data for an address presented in cycle t appears at cycle t+RD_LAT.
REQ-022 Data port, read and write to the same word in the same cycle: write-first. DATA_IN returns the merged new word.
REQ-023 Instruction port reading the word being written by the data port in the same cycle: read-first. INSTR returns the old word.
REQ-024 With RD_LAT=2, the extra output register stage SHALL advance every cycle. There is no stall input.

Reset
REQ-025 While RESET=1: FSM=IDLE, cnt=0, READY=0, INSTR=0, DATA_IN=0, and all read pipeline stages = 0.
REQ-026 RESET asserted during INIT SHALL abort the sweep. On release the sweep SHALL restart from word 0.
REQ-027 Memory contents SHALL NOT be cleared by RESET itself; only the INIT sweep clears them.

Structure
REQ-028 Package steel_mem_pkg SHALL hold the FSM state enum (IDLE/INIT/RUN) and the RD_LAT legality constant.
REQ-029 One sub-module, steel_mem_rdpipe, SHALL implement the parametrised RD_LAT output register stage. It is instantiated once per port.
REQ-030 Storage SHALL be a single array inferable as a true dual-port RAM with byte-enable writes.

Verification (ADDR_W=4, DATA_W=32, INIT_ZERO=1 unless stated)
REQ-031 Release RESET -> READY=0 for exactly 16 cycles, then 1. Reading words 0..15 then returns 0x00000000.
REQ-032 RUN: write D_ADDR=0x8, DATA_OUT=0xDEADBEEF, WR_MASK=0xF. Then write 0x8 with 0x11223344 and WR_MASK=0x3 -> DATA_IN=0xDEAD3344 after RD_LAT cycles.
REQ-033 Same cycle: D_ADDR=I_ADDR=0x4, old word 0xAAAAAAAA, write 0x55555555 with mask 0xF -> DATA_IN=0x55555555 and INSTR=0xAAAAAAAA.
REQ-034 Alias: write D_ADDR=0x40 with 0x12345678 -> reading I_ADDR=0x0 and I_ADDR=0x3 both give 0x12345678. WR_REQ=0 with WR_MASK=0xF leaves the word unchanged.
REQ-035 RESET pulsed at sweep cycle 7 -> READY stays 0 for a fresh 16 cycles after release. Pre-reset contents are cleared by the new sweep.
REQ-036 Run REQ-032 with RD_LAT=2 -> identical data one cycle later. With INIT_ZERO=0, READY=1 on the first cycle after reset.
